// File: rtl/alu_rs.sv
// Reservation station for integer ALU ops: holds dispatched ops until both operands are known, then issues one per cycle.
// Optional oldest-first issue selection is enabled by defining ALU_RS_OLDEST_FIRST_EN.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 disp_valid,
    input  logic [2:0]           disp_op_L1,
    input  logic                 disp_op_L2,
    input  logic [ROB_WIDTH-1:0] disp_rob_id,
    input  logic [31:0]          disp_vj,
    input  logic [31:0]          disp_vk,
    input  logic                 disp_qj_valid,
    input  logic                 disp_qk_valid,
    input  logic [ROB_WIDTH-1:0] disp_qj,
    input  logic [ROB_WIDTH-1:0] disp_qk,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]          lsb_cdb_value,
    output logic                 full_out,
    output logic                 alu_valid,
    output logic [31:0]          alu_opr1,
    output logic [31:0]          alu_opr2,
    output logic [2:0]           alu_op_L1,
    output logic                 alu_op_L2,
    output logic [ROB_WIDTH-1:0] alu_rob_id
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   ready;
    logic [2:0]           ent_op_l1   [RS_SIZE];
    logic                 ent_op_l2   [RS_SIZE];
    logic [ROB_WIDTH-1:0] ent_rob_id  [RS_SIZE];
    logic [31:0]          ent_vj      [RS_SIZE];
    logic [31:0]          ent_vk      [RS_SIZE];
    logic                 ent_qj_valid[RS_SIZE];
    logic [ROB_WIDTH-1:0] ent_qj      [RS_SIZE];
    logic                 ent_qk_valid[RS_SIZE];
    logic [ROB_WIDTH-1:0] ent_qk      [RS_SIZE];

    logic             dispatch;
    logic [IDX_W-1:0] free_idx;
    logic             issue_found;
    logic [IDX_W-1:0] issue_idx;
    logic             new_qj_valid;
    logic             new_qk_valid;
    logic [31:0]      new_vj;
    logic [31:0]      new_vk;

    assign full_out = &busy;
    assign dispatch = disp_valid && !full_out;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && !ent_qj_valid[i] && !ent_qk_valid[i];
        end
    end

    // Dispatch bypass: a pending operand whose producer broadcasts this cycle is captured directly.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        new_qj_valid = disp_qj_valid;
        new_vj       = disp_vj;
        new_qk_valid = disp_qk_valid;
        new_vk       = disp_vk;
        if (disp_qj_valid && alu_cdb_valid && alu_cdb_rob_id == disp_qj) begin
            new_qj_valid = 1'b0;
            new_vj       = alu_cdb_value;
        end else if (disp_qj_valid && lsb_cdb_valid && lsb_cdb_rob_id == disp_qj) begin
            new_qj_valid = 1'b0;
            new_vj       = lsb_cdb_value;
        end
        if (disp_qk_valid && alu_cdb_valid && alu_cdb_rob_id == disp_qk) begin
            new_qk_valid = 1'b0;
            new_vk       = alu_cdb_value;
        end else if (disp_qk_valid && lsb_cdb_valid && lsb_cdb_rob_id == disp_qk) begin
            new_qk_valid = 1'b0;
            new_vk       = lsb_cdb_value;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    localparam int AGE_W = IDX_W + 1;

    logic [AGE_W-1:0] age [RS_SIZE];
    logic [AGE_W-1:0] best_age;

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        best_age    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!issue_found || age[i] > best_age)) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
                best_age    = age[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else if (rdy_in && !clear_in && dispatch) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && age[i] != '1) age[i] <= age[i] + 1'b1;
            end
            age[free_idx] <= '0;
        end
    end
`else
    always_comb begin
        issue_found = |ready;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) issue_idx = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_in) begin
            busy       <= '0;
            alu_valid  <= 1'b0;
            alu_opr1   <= '0;
            alu_opr2   <= '0;
            alu_op_L1  <= '0;
            alu_op_L2  <= 1'b0;
            alu_rob_id <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                alu_valid <= issue_found;
                if (issue_found) begin
                    alu_opr1          <= ent_vj[issue_idx];
                    alu_opr2          <= ent_vk[issue_idx];
                    alu_op_L1         <= ent_op_l1[issue_idx];
                    alu_op_L2         <= ent_op_l2[issue_idx];
                    alu_rob_id        <= ent_rob_id[issue_idx];
                    busy[issue_idx]   <= 1'b0;
                end
                if (dispatch) busy[free_idx] <= 1'b1;
            end
        end
    end

    // NOTE: entry payload is not reset; busy alone qualifies every entry, so stale contents are never observed.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && ent_qj_valid[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == ent_qj[i]) begin
                        ent_vj[i]       <= alu_cdb_value;
                        ent_qj_valid[i] <= 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent_qj[i]) begin
                        ent_vj[i]       <= lsb_cdb_value;
                        ent_qj_valid[i] <= 1'b0;
                    end
                end
                if (busy[i] && ent_qk_valid[i]) begin
                    if (alu_cdb_valid && alu_cdb_rob_id == ent_qk[i]) begin
                        ent_vk[i]       <= alu_cdb_value;
                        ent_qk_valid[i] <= 1'b0;
                    end else if (lsb_cdb_valid && lsb_cdb_rob_id == ent_qk[i]) begin
                        ent_vk[i]       <= lsb_cdb_value;
                        ent_qk_valid[i] <= 1'b0;
                    end
                end
            end
            if (dispatch) begin
                ent_op_l1[free_idx]    <= disp_op_L1;
                ent_op_l2[free_idx]    <= disp_op_L2;
                ent_rob_id[free_idx]   <= disp_rob_id;
                ent_vj[free_idx]       <= new_vj;
                ent_vk[free_idx]       <= new_vk;
                ent_qj_valid[free_idx] <= new_qj_valid;
                ent_qj[free_idx]       <= disp_qj;
                ent_qk_valid[free_idx] <= new_qk_valid;
                ent_qk[free_idx]       <= disp_qk;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios against fixed values, then random traffic
// against a cycle-level behavioural model of the station's rules.
module tb_alu_rs;
    localparam int RS = 8;
    localparam int RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rdy, clr, dv, dop2, dqjv, dqkv, acv, lcv;
    logic [2:0]    dop1;
    logic [RW-1:0] drob, dqj, dqk, arob, lrob;
    logic [31:0]   dvj, dvk, aval, lval;
    logic          full_out, alu_valid, alu_op_L2;
    logic [31:0]   alu_opr1, alu_opr2;
    logic [2:0]    alu_op_L1;
    logic [RW-1:0] alu_rob_id;

    alu_rs #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
        .disp_valid(dv), .disp_op_L1(dop1), .disp_op_L2(dop2), .disp_rob_id(drob),
        .disp_vj(dvj), .disp_vk(dvk), .disp_qj_valid(dqjv), .disp_qk_valid(dqkv),
        .disp_qj(dqj), .disp_qk(dqk),
        .alu_cdb_valid(acv), .alu_cdb_rob_id(arob), .alu_cdb_value(aval),
        .lsb_cdb_valid(lcv), .lsb_cdb_rob_id(lrob), .lsb_cdb_value(lval),
        .full_out(full_out), .alu_valid(alu_valid), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2),
        .alu_op_L1(alu_op_L1), .alu_op_L2(alu_op_L2), .alu_rob_id(alu_rob_id)
    );

    typedef struct {
        bit          busy;
        bit [2:0]    op1;
        bit          op2;
        bit [RW-1:0] rob;
        bit [31:0]   vj, vk;
        bit          jp, kp;
        bit [RW-1:0] qj, qk;
        int          age;
    } ent_t;

    ent_t        m[RS];
    bit          e_valid, e_op2, e_full;
    bit [31:0]   e_o1, e_o2;
    bit [2:0]    e_op1;
    bit [RW-1:0] e_rob;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Operand lookup against this cycle's broadcasts; ALU port wins. Returns {still_pending, value}.
    function automatic logic [32:0] snoop(input logic pend, input logic [RW-1:0] tag, input logic [31:0] val);
        if (!pend) return {1'b0, val};
        if (acv && arob == tag) return {1'b0, aval};
        if (lcv && lrob == tag) return {1'b0, lval};
        return {1'b1, val};
    endfunction

    task automatic model_step();
        ent_t        nxt[RS];
        int          pick, free;
        bit          full;
        logic [32:0] r;
        if (rst) begin
            for (int i = 0; i < RS; i++) begin m[i].busy = 0; m[i].age = 0; end
            e_valid = 0; e_o1 = 0; e_o2 = 0; e_op1 = 0; e_op2 = 0; e_rob = 0;
        end else if (rdy) begin
            if (clr) begin
                for (int i = 0; i < RS; i++) m[i].busy = 0;
                e_valid = 0;
            end else begin
                nxt = m;
                full = 1; free = -1; pick = -1;
                for (int i = 0; i < RS; i++) if (!m[i].busy) begin full = 0; if (free < 0) free = i; end
                for (int i = 0; i < RS; i++) begin
                    if (m[i].busy && !m[i].jp && !m[i].kp) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
                        if (pick < 0 || m[i].age > m[pick].age) pick = i;
`else
                        if (pick < 0) pick = i;
`endif
                    end
                end
                for (int i = 0; i < RS; i++) begin
                    if (m[i].busy) begin
                        r = snoop(m[i].jp, m[i].qj, m[i].vj); nxt[i].jp = r[32]; nxt[i].vj = r[31:0];
                        r = snoop(m[i].kp, m[i].qk, m[i].vk); nxt[i].kp = r[32]; nxt[i].vk = r[31:0];
                    end
                end
                e_valid = (pick >= 0);
                if (pick >= 0) begin
                    e_o1 = m[pick].vj; e_o2 = m[pick].vk; e_op1 = m[pick].op1;
                    e_op2 = m[pick].op2; e_rob = m[pick].rob; nxt[pick].busy = 0;
                end
                if (dv && !full) begin
                    for (int i = 0; i < RS; i++) if (m[i].busy && m[i].age < 2 * RS - 1) nxt[i].age = nxt[i].age + 1;
                    nxt[free].busy = 1; nxt[free].op1 = dop1; nxt[free].op2 = dop2; nxt[free].rob = drob;
                    nxt[free].qj = dqj; nxt[free].qk = dqk; nxt[free].age = 0;
                    r = snoop(dqjv, dqj, dvj); nxt[free].jp = r[32]; nxt[free].vj = r[31:0];
                    r = snoop(dqkv, dqk, dvk); nxt[free].kp = r[32]; nxt[free].vk = r[31:0];
                end
                m = nxt;
            end
        end
        e_full = 1;
        for (int i = 0; i < RS; i++) if (!m[i].busy) e_full = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; clr = 0; dv = 0; acv = 0; lcv = 0; dqjv = 0; dqkv = 0;
    endtask

    task automatic disp(input logic [2:0] op1, input logic op2, input logic [RW-1:0] rob,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic jp, input logic [RW-1:0] qj, input logic kp, input logic [RW-1:0] qk);
        dv = 1; dop1 = op1; dop2 = op2; drob = rob; dvj = vj; dvk = vk;
        dqjv = jp; dqj = qj; dqkv = kp; dqk = qk;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", alu_valid); end
        n_cmp++; if (alu_opr1 !== 32'd0) begin n_bad++; $display("FAIL reset_opr1: got %h want 0", alu_opr1); end
        n_cmp++; if (alu_opr2 !== 32'd0) begin n_bad++; $display("FAIL reset_opr2: got %h want 0", alu_opr2); end
        n_cmp++; if ({alu_op_L1, alu_op_L2} !== 4'd0) begin n_bad++; $display("FAIL reset_op: got %0d/%0b want 0/0", alu_op_L1, alu_op_L2); end
        n_cmp++; if (alu_rob_id !== 4'd0) begin n_bad++; $display("FAIL reset_rob: got %0d want 0", alu_rob_id); end
        n_cmp++; if (full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", full_out); end
    endtask

    task automatic test_basic();
        disp(3'd0, 1'b0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0); tick(); idle();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: valid got %0b want 0", alu_valid); end
        tick();
        n_cmp++; if ({alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_op_L2, alu_rob_id} !== {1'b1, 32'd5, 32'd7, 3'd0, 1'b0, 4'd3})
            begin n_bad++; $display("FAIL basic_issue: got v=%0b o1=%h o2=%h op=%0d/%0b rob=%0d want v=1 o1=5 o2=7 op=0/0 rob=3", alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_op_L2, alu_rob_id); end
        tick();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL basic_after: valid got %0b want 0", alu_valid); end
    endtask

    task automatic test_wakeup();
        disp(3'd0, 1'b1, 4'd2, 32'hDEAD, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0); tick(); idle();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL wake_pend1: valid got %0b want 0", alu_valid); end
        lcv = 1; lrob = 4'd4; lval = 32'hBAD; tick(); idle();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL wake_wrongtag: valid got %0b want 0", alu_valid); end
        acv = 1; arob = 4'd5; aval = 32'h10; tick(); idle();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL wake_samecycle: valid got %0b want 0", alu_valid); end
        tick();
        n_cmp++; if ({alu_valid, alu_opr1, alu_opr2, alu_op_L2, alu_rob_id} !== {1'b1, 32'h10, 32'd1, 1'b1, 4'd2})
            begin n_bad++; $display("FAIL wake_issue: got v=%0b o1=%h o2=%h op2=%0b rob=%0d want v=1 o1=10 o2=1 op2=1 rob=2", alu_valid, alu_opr1, alu_opr2, alu_op_L2, alu_rob_id); end
        tick();
    endtask

    task automatic test_bypass();
        disp(3'd7, 1'b0, 4'd7, 32'h22, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6);
        lcv = 1; lrob = 4'd6; lval = 32'hFFFF_FFFF; tick(); idle();
        tick();
        n_cmp++; if ({alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_rob_id} !== {1'b1, 32'h22, 32'hFFFF_FFFF, 3'd7, 4'd7})
            begin n_bad++; $display("FAIL bypass_lsb: got v=%0b o1=%h o2=%h op1=%0d rob=%0d want v=1 o1=22 o2=ffffffff op1=7 rob=7", alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_rob_id); end
        // Both ports carry tag 0: ALU value must win.
        disp(3'd1, 1'b0, 4'd0, 32'd0, 32'd3, 1'b1, 4'd0, 1'b0, 4'd0);
        acv = 1; arob = 4'd0; aval = 32'hA; lcv = 1; lrob = 4'd0; lval = 32'hB; tick(); idle();
        tick();
        n_cmp++; if ({alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_rob_id} !== {1'b1, 32'hA, 32'd3, 3'd1, 4'd0})
            begin n_bad++; $display("FAIL bypass_prio: got v=%0b o1=%h o2=%h op1=%0d rob=%0d want v=1 o1=a o2=3 op1=1 rob=0", alu_valid, alu_opr1, alu_opr2, alu_op_L1, alu_rob_id); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            disp(3'd4, 1'b0, RW'(i), 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0); tick();
        end
        idle();
        n_cmp++; if ({full_out, alu_valid} !== 2'b10) begin n_bad++; $display("FAIL full_set: got full=%0b v=%0b want full=1 v=0", full_out, alu_valid); end
        disp(3'd0, 1'b0, 4'd15, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); tick(); idle();
        n_cmp++; if ({full_out, alu_valid} !== 2'b10) begin n_bad++; $display("FAIL full_ignore: got full=%0b v=%0b want full=1 v=0", full_out, alu_valid); end
        acv = 1; arob = 4'd9; aval = 32'h100; tick(); idle();
        for (int k = 0; k < RS; k++) begin
            tick();
            n_cmp++; if ({alu_valid, alu_rob_id, alu_opr1, alu_opr2} !== {1'b1, RW'(k), 32'h100, 32'(k)})
                begin n_bad++; $display("FAIL full_drain[%0d]: got v=%0b rob=%0d o1=%h o2=%h want v=1 rob=%0d o1=100 o2=%h", k, alu_valid, alu_rob_id, alu_opr1, alu_opr2, k, k); end
            if (k == 0) begin
                n_cmp++; if (full_out !== 1'b0) begin n_bad++; $display("FAIL full_drop: got %0b want 0", full_out); end
            end
        end
        tick();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL full_ninth: valid got %0b want 0", alu_valid); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            disp(3'd2, 1'b0, RW'(i + 8), 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd12); tick();
        end
        clr = 1; disp(3'd0, 1'b0, 4'd1, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); tick(); idle();
        n_cmp++; if ({full_out, alu_valid} !== 2'b00) begin n_bad++; $display("FAIL clear_now: got full=%0b v=%0b want 0/0", full_out, alu_valid); end
        acv = 1; arob = 4'd12; aval = 32'h55; tick(); idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL clear_noissue[%0d]: valid got %0b want 0", k, alu_valid); end
        end
    endtask

    task automatic test_stall();
        disp(3'd0, 1'b0, 4'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0); tick();
        disp(3'd0, 1'b0, 4'd6, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0); tick(); idle();
        rdy = 0; disp(3'd0, 1'b0, 4'd7, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0);
        acv = 1; arob = 4'd1; aval = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({alu_valid, alu_rob_id, alu_opr1, alu_opr2} !== {1'b1, 4'd5, 32'd1, 32'd2})
                begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%0b rob=%0d o1=%h o2=%h want v=1 rob=5 o1=1 o2=2", k, alu_valid, alu_rob_id, alu_opr1, alu_opr2); end
        end
        idle(); tick();
        n_cmp++; if ({alu_valid, alu_rob_id, alu_opr1} !== {1'b1, 4'd6, 32'd3})
            begin n_bad++; $display("FAIL stall_resume: got v=%0b rob=%0d o1=%h want v=1 rob=6 o1=3", alu_valid, alu_rob_id, alu_opr1); end
        tick();
        n_cmp++; if (alu_valid !== 1'b0) begin n_bad++; $display("FAIL stall_dropdisp: valid got %0b want 0", alu_valid); end
    endtask

    task automatic test_random();
        idle(); rst = 1; tick(); idle();
        for (int c = 0; c < 600; c++) begin
            if (c < 540) begin
                disp(3'($urandom), 1'($urandom), RW'($urandom), $urandom, $urandom,
                     1'($urandom), RW'($urandom_range(0, 3)), 1'($urandom), RW'($urandom_range(0, 3)));
                dv   = ($urandom_range(0, 2) != 0);
                acv  = ($urandom_range(0, 2) == 0); arob = RW'($urandom_range(0, 3)); aval = $urandom;
                lcv  = ($urandom_range(0, 2) == 0); lrob = RW'($urandom_range(0, 3)); lval = $urandom;
                rdy  = ($urandom_range(0, 7) != 0);
                clr  = ($urandom_range(0, 79) == 0);
            end else begin
                idle(); acv = 1; arob = RW'(c % 4); aval = $urandom;
            end
            tick();
            n_cmp++;
            if (alu_valid !== e_valid || full_out !== e_full ||
                (e_valid && {alu_opr1, alu_opr2, alu_op_L1, alu_op_L2, alu_rob_id} !== {e_o1, e_o2, e_op1, e_op2, e_rob})) begin
                n_bad++;
                $display("FAIL rand[%0d]: got v=%0b f=%0b rob=%0d o1=%h o2=%h op=%0d/%0b want v=%0b f=%0b rob=%0d o1=%h o2=%h op=%0d/%0b",
                         c, alu_valid, full_out, alu_rob_id, alu_opr1, alu_opr2, alu_op_L1, alu_op_L2,
                         e_valid, e_full, e_rob, e_o1, e_o2, e_op1, e_op2);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        dop1 = 0; dop2 = 0; drob = 0; dvj = 0; dvk = 0; dqj = 0; dqk = 0;
        arob = 0; aval = 0; lrob = 0; lval = 0;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
